// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for the shared 8-bit ALU.
// Two requesters, one op in flight; multiply held MUL_LAT cycles.
//
// Ports:
//   clk_in, rstn_in               clock, async active-low reset
//   req_in[1:0], gnt_out[1:0]     request / combinational grant
//   unit_selN_in, op_selN_in,
//   accN_in, srcN_in              per-requester operation fields
//   alu_*_out, alu_res_in         registered ALU drive, ALU result
//   rsp_valid_out, rsp_ready_in   per-requester response handshake
//   rsp_data_out                  captured result (shared)
//   busy_out                      high while an op is in EXEC/RESP
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic [1:0] req_in,
    output logic [1:0] gnt_out,
    input  logic [2:0] unit_sel0_in,
    input  logic [2:0] unit_sel1_in,
    input  logic       op_sel0_in,
    input  logic       op_sel1_in,
    input  logic [7:0] acc0_in,
    input  logic [7:0] acc1_in,
    input  logic [7:0] src0_in,
    input  logic [7:0] src1_in,
    output logic [2:0] alu_unit_sel_out,
    output logic       alu_op_sel_out,
    output logic [7:0] alu_acc_out,
    output logic [7:0] alu_src_out,
    input  logic [7:0] alu_res_in,
    output logic [1:0] rsp_valid_out,
    output logic [7:0] rsp_data_out,
    input  logic [1:0] rsp_ready_in,
    output logic       busy_out
);

    localparam logic [2:0] UNIT_MUL = 3'b110;
    localparam logic [2:0] MUL_CNT  = 3'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       ptr;
    logic       id;
    logic [2:0] cnt;
    logic       hs;
    logic       winner;
    logic       accept;
    logic [2:0] win_unit;

    // Grant is only offered from IDLE or on the cycle the owner
    // completes its handshake, so accept can overlap the response.
    always_comb begin
        hs        = (state == S_RESP) && rsp_ready_in[id];
        winner    = ptr;
        case (req_in)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ptr;
        endcase
        accept    = rstn_in && (req_in != 2'b00) &&
                    ((state == S_IDLE) || hs);
        gnt_out   = 2'b00;
        if (accept)
            gnt_out = winner ? 2'b10 : 2'b01;
        win_unit  = winner ? unit_sel1_in : unit_sel0_in;

        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_EXEC;
            S_EXEC: if (cnt == 3'd0) state_nxt = S_RESP;
            S_RESP: if (hs) state_nxt = accept ? S_EXEC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        rsp_valid_out = 2'b00;
        if (state == S_RESP)
            rsp_valid_out = id ? 2'b10 : 2'b01;
        busy_out = (state != S_IDLE);
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            ptr              <= 1'b0;
            id               <= 1'b0;
            cnt              <= 3'd0;
            alu_unit_sel_out <= 3'd0;
            alu_op_sel_out   <= 1'b0;
            alu_acc_out      <= 8'h00;
            alu_src_out      <= 8'h00;
            rsp_data_out     <= 8'h00;
        end else begin
            if (accept) begin
                ptr              <= ~winner;
                id               <= winner;
                alu_unit_sel_out <= win_unit;
                alu_op_sel_out   <= winner ? op_sel1_in : op_sel0_in;
                alu_acc_out      <= winner ? acc1_in : acc0_in;
                alu_src_out      <= winner ? src1_in : src0_in;
                cnt <= (win_unit == UNIT_MUL) ? MUL_CNT : 3'd0;
            end else if (state == S_EXEC) begin
                if (cnt != 3'd0)
                    cnt <= cnt - 3'd1;
                else
                    rsp_data_out <= alu_res_in;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 8-bit ALU. It accepts operations from requester 0 (core sequencer) and requester 1 (auxiliary/debug port) and arbitrates between them round-robin. It drives the ALU operand/select lines from registers, holds the multiply for a configurable number of cycles, and returns the captured result on a per-requester valid/ready response channel. One operation is in flight at a time.

## Interface
- MUL_LAT, 2: EXEC cycles for unit_sel 3'b110 (multiply); legal 1..7. All other units use 1 EXEC cycle.

- clk_in  input  1  clock, rising edge
- rstn_in  input  1  asynchronous reset, active-low
- req_in  input  2  request per requester, bit i = requester i
- gnt_out  output  2  grant, combinational, at most one bit set; accept = req_in[i] & gnt_out[i]
- unit_sel0_in / unit_sel1_in  input  3  ALU unit select per requester
- op_sel0_in / op_sel1_in  input  1  ALU op modifier per requester
- acc0_in / acc1_in  input  8  accumulator operand per requester
- src0_in / src1_in  input  8  source operand per requester
- alu_unit_sel_out  output  3  registered, to ALU
- alu_op_sel_out  output  1  registered, to ALU
- alu_acc_out  output  8  registered, to ALU
- alu_src_out  output  8  registered, to ALU
- alu_res_in  input  8  ALU combinational result
- rsp_valid_out  output  2  response valid, bit i = owner requester
- rsp_data_out  output  8  captured result, shared by both requesters
- rsp_ready_in  input  2  response ready per requester
- busy_out  output  1  high in EXEC or RESP

## Operation
- FSM states:
  - IDLE: accept a request if any is present.
  - EXEC: count down the execution cycles.
  - RESP: hold the response until the owner takes it.
- Grant eligibility: gnt_out may be non-zero only in IDLE, or in RESP during the cycle the owner's response handshake (rsp_valid_out[id] & rsp_ready_in[id]) completes.
- Arbitration:
  - Priority pointer ptr (1 bit), reset 0.
  - If only one requester is requesting, it wins.
  - If both are requesting, requester ptr wins.
  - After every accept, ptr is set to the non-winner.
- On accept:
  - The winner's unit_sel/op_sel/acc/src are registered into the alu_* outputs.
  - id <= winner.
  - The cycle counter is loaded with MUL_LAT-1 for 3'b110, otherwise 0.
  - State -> EXEC.
- Requester operands are sampled only in the accept cycle; they need not be held afterwards.
- EXEC:
  - While the counter is non-zero, decrement it.
  - When the counter is zero, capture alu_res_in into rsp_data_out and go to RESP.
- RESP:
  - rsp_valid_out = one-hot(id).
  - rsp_data_out and alu_* outputs are stable.
  - On handshake: go to EXEC if a new request is accepted in that same cycle, otherwise go to IDLE.
- The rsp_ready_in bit of the non-owner is ignored.
- alu_* outputs keep their last values in IDLE; there is no clearing between operations.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Reset (rstn_in low, asynchronous) forces:
  - State IDLE, ptr 0, id 0, counter 0.
  - alu_* outputs 0, rsp_data_out 0x00.
  - rsp_valid_out 00, busy_out 0.
  - gnt_out is 00 while reset is asserted.
- Reset mid-operation discards the in-flight operation. No response is produced for it.
- Latency, accept at cycle T:
  - alu_* outputs valid from T+1.
  - Non-multiply: rsp_valid_out rises at T+2.
  - Multiply: rsp_valid_out rises at T+1+MUL_LAT.
- Throughput with an always-ready consumer: one non-multiply op every 2 cycles (accept overlaps the response handshake).
- Backpressure: while the response is not taken, gnt_out = 00 and all outputs hold.
- Simultaneous events:
  - A handshake plus a new request in the same cycle gives a same-cycle grant.
  - A request from the owner of the completing response is eligible in that cycle, subject to ptr.

## Test plan
- Single add, ALU instance attached:
  - Stimulus: req_in=01, unit_sel0=000, op_sel0=0, acc0=0x05, src0=0x03, rsp_ready_in=01 at T.
  - Required: gnt_out=01 at T; alu_acc_out=0x05 at T+1; rsp_valid_out=01 and rsp_data_out=0x08 at T+2; busy_out low at T+3.
- Contention:
  - Stimulus: req_in=11 held continuously, both ready.
  - Required: grants alternate 01,10,01,10; ptr starts 0; each response is routed to the matching rsp_valid_out bit.
- Multiply with MUL_LAT=2:
  - Stimulus: acc1=0x07, src1=0x06, unit_sel1=110, req_in=10 at T.
  - Required: rsp_valid_out=10 at T+3, rsp_data_out=0x2A.
  - Repeat with MUL_LAT=4: rsp_valid_out at T+5.
- Backpressure:
  - Stimulus: requester 0 sub 0x10-0x01, rsp_ready_in=00 for 5 cycles while req_in=10.
  - Required: rsp_data_out=0x0F stable; gnt_out=00 throughout; when ready rises, gnt_out=10 in that same cycle.
- Back-to-back:
  - Stimulus: ready always 1, requester 0 issues 4 consecutive AND ops.
  - Required: accepts at T, T+2, T+4, T+6, results in order.
  - Also: rsp_ready_in[1] high while owner 0 is pending must not complete the response.
- Reset mid-EXEC:
  - Stimulus: drop rstn_in during the multiply EXEC.
  - Required: outputs 0 immediately (asynchronous); after release, no stray rsp_valid_out; the next request is granted from IDLE with ptr=0.
